// File: rtl/ldm_stm_seq_pkg.sv
// ldm_stm_seq_pkg: shared CPU constants and the block-transfer sequencer state encoding.
package ldm_stm_seq_pkg;
   typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
   localparam int unsigned WORD_STRIDE = 4;
endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// prio_enc16: index of the lowest set bit of a 16-bit mask plus a nonzero flag.
module prio_enc16 (
   input  logic [15:0] i_mask,
   output logic [3:0]  o_idx,
   output logic        o_valid
);
   always_comb begin
      o_idx = '0;
      for (int i = 15; i >= 0; i--)
         if (i_mask[i]) o_idx = 4'(i);
   end
   assign o_valid = |i_mask;
endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: LDM/STM block-transfer sequencer, one memory beat per selected register.
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          IS_LOAD,
   input  logic          UP,
   input  logic [15:0]   REG_LIST,
   input  logic [DW-1:0] BASE_ADDR,
   output logic [3:0]    RF_RADDR,
   input  logic [DW-1:0] RF_RDATA,
   output logic [3:0]    RF_WADDR,
   output logic [DW-1:0] RF_WDATA,
   output logic          RF_WEN,
   output logic          MEM_REQ,
   output logic          MEM_WE,
   output logic [DW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic          MEM_ACK,
   input  logic [DW-1:0] MEM_RDATA,
   output logic          BUSY,
   output logic          DONE,
   output logic [DW-1:0] WB_ADDR
);
   state_t        r_state;
   logic          r_is_load;
   logic [15:0]   r_mask;
   logic [DW-1:0] r_addr;
   logic [DW-1:0] r_wb;
   logic          r_rf_wen;
   logic [3:0]    r_rf_waddr;
   logic [DW-1:0] r_rf_wdata;
   logic [3:0]    w_idx;
   logic          w_valid;
   logic [4:0]    w_cnt;
   logic [DW-1:0] w_span;
   logic          w_beat;
   logic          w_last;

   prio_enc16 u_enc (
      .i_mask  (r_mask),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < 16; i++)
         w_cnt = w_cnt + 5'(REG_LIST[i]);
   end

   assign w_span = DW'(w_cnt) * DW'(WORD_STRIDE);
   assign w_beat = (r_state == XFER) && w_valid && MEM_ACK;
   // the beat in flight is the last one when it is the only bit left in the mask
   assign w_last = (r_mask & (r_mask - 16'd1)) == '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_is_load  <= 1'b0;
         r_mask     <= '0;
         r_addr     <= '0;
         r_wb       <= '0;
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_wen <= 1'b0;
         case (r_state)
            IDLE: if (START) begin
               r_is_load <= IS_LOAD;
               r_mask    <= REG_LIST;
               r_addr    <= UP ? BASE_ADDR : BASE_ADDR - w_span;
               r_wb      <= UP ? BASE_ADDR + w_span : BASE_ADDR - w_span;
               r_state   <= (REG_LIST == '0) ? FIN : XFER;
            end
            XFER: if (w_beat) begin
               r_mask     <= r_mask & ~(16'd1 << w_idx);
               r_addr     <= r_addr + DW'(WORD_STRIDE);
               r_rf_wen   <= r_is_load;
               r_rf_waddr <= w_idx;
               r_rf_wdata <= MEM_RDATA;
               if (w_last) r_state <= FIN;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign BUSY      = r_state != IDLE;
   assign DONE      = r_state == FIN;
   assign MEM_REQ   = r_state == XFER;
   assign MEM_WE    = MEM_REQ && !r_is_load;
   assign MEM_ADDR  = r_addr;
   assign MEM_WDATA = MEM_WE ? RF_RDATA : '0;
   assign RF_RADDR  = w_idx;
   assign RF_WEN    = r_rf_wen;
   assign RF_WADDR  = r_rf_waddr;
   assign RF_WDATA  = r_rf_wdata;
   assign WB_ADDR   = r_wb;
endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: randomized LDM/STM transfers checked against a list-of-beats reference model.
module tb_ldm_stm_seq;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        IS_LOAD = 1'b0;
   logic        UP = 1'b0;
   logic [15:0] REG_LIST = '0;
   logic [31:0] BASE_ADDR = '0;
   logic [3:0]  RF_RADDR;
   logic [31:0] RF_RDATA;
   logic [3:0]  RF_WADDR;
   logic [31:0] RF_WDATA;
   logic        RF_WEN;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_RDATA = '0;
   logic        BUSY;
   logic        DONE;
   logic [31:0] WB_ADDR;
   logic [31:0] rf [16];
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;
   assign RF_RDATA = rf[RF_RADDR];

   ldm_stm_seq #(.DW(32)) dut (
      .CLK(CLK), .RST(RST), .START(START), .IS_LOAD(IS_LOAD), .UP(UP),
      .REG_LIST(REG_LIST), .BASE_ADDR(BASE_ADDR), .RF_RADDR(RF_RADDR),
      .RF_RDATA(RF_RDATA), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
      .RF_WEN(RF_WEN), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
      .BUSY(BUSY), .DONE(DONE), .WB_ADDR(WB_ADDR)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_req"}, 32'(MEM_REQ), 0);
      chk({tag, "_we"}, 32'(MEM_WE), 0);
      chk({tag, "_rfwen"}, 32'(RF_WEN), 0);
      chk({tag, "_addr"}, MEM_ADDR, 0);
      chk({tag, "_wdata"}, MEM_WDATA, 0);
      chk({tag, "_rfwaddr"}, 32'(RF_WADDR), 0);
      chk({tag, "_rfwdata"}, RF_WDATA, 0);
      chk({tag, "_wb"}, WB_ADDR, 0);
      chk({tag, "_rfraddr"}, 32'(RF_RADDR), 0);
   endtask

   task automatic run(input bit ld, input bit up, input logic [15:0] m, input logic [31:0] base,
                      input int wmin, input int wmax, input bit poke);
      int          idx_q[$];
      int          n, k, w, guard;
      logic [31:0] start, wb, d, pdata;
      logic [3:0]  pidx;
      bit          pend;
      for (int i = 0; i < 16; i++)
         if (m[i]) idx_q.push_back(i);
      n = idx_q.size();
      start = up ? base : base - 32'(4 * n);
      wb = up ? base + 32'(4 * n) : base - 32'(4 * n);
      @(negedge CLK);
      chk("idle_busy", 32'(BUSY), 0);
      START = 1'b1; IS_LOAD = ld; UP = up; REG_LIST = m; BASE_ADDR = base;
      MEM_ACK = 1'($urandom);
      @(negedge CLK);
      START = 1'b0; MEM_ACK = 1'b0;
      chk("wb_addr", WB_ADDR, wb);
      k = 0; guard = 0; pend = 1'b0; pidx = '0; pdata = '0;
      w = $urandom_range(wmax, wmin);
      while (k < n && guard < 400) begin
         if (pend) begin
            chk("rf_wen", 32'(RF_WEN), 1);
            chk("rf_waddr", 32'(RF_WADDR), 32'(pidx));
            chk("rf_wdata", RF_WDATA, pdata);
            pend = 1'b0;
         end else chk("rf_wen_quiet", 32'(RF_WEN), 0);
         chk("mem_req", 32'(MEM_REQ), 1);
         chk("busy", 32'(BUSY), 1);
         chk("done_early", 32'(DONE), 0);
         chk("mem_addr", MEM_ADDR, start + 32'(4 * k));
         chk("mem_we", 32'(MEM_WE), 32'(!ld));
         if (!ld) begin
            chk("rf_raddr", 32'(RF_RADDR), 32'(idx_q[k]));
            chk("mem_wdata", MEM_WDATA, rf[idx_q[k]]);
         end
         if (poke) begin
            IS_LOAD = 1'($urandom); UP = 1'($urandom);
            REG_LIST = 16'($urandom); BASE_ADDR = $urandom;
            START = (guard == 0);
         end
         d = $urandom;
         MEM_RDATA = d;
         if (w == 0) begin
            MEM_ACK = 1'b1;
            if (ld) begin pend = 1'b1; pidx = 4'(idx_q[k]); pdata = d; end
            k++;
            if (k < n) w = $urandom_range(wmax, wmin);
         end else begin
            MEM_ACK = 1'b0;
            w--;
         end
         @(negedge CLK);
         MEM_ACK = 1'b0; START = 1'b0;
         guard++;
      end
      chk("beats", 32'(k), 32'(n));
      chk("done", 32'(DONE), 1);
      chk("fin_busy", 32'(BUSY), 1);
      chk("fin_req", 32'(MEM_REQ), 0);
      chk("fin_rfwen", 32'(RF_WEN), 32'(pend));
      if (pend) begin
         chk("fin_rfwaddr", 32'(RF_WADDR), 32'(pidx));
         chk("fin_rfwdata", RF_WDATA, pdata);
      end
      MEM_ACK = 1'($urandom);
      @(negedge CLK);
      MEM_ACK = 1'b0;
      chk("done_clear", 32'(DONE), 0);
      chk("idle_after", 32'(BUSY), 0);
      chk("rfwen_after", 32'(RF_WEN), 0);
      chk("wb_hold", WB_ADDR, wb);
   endtask

   task automatic reset_mid_ldm();
      @(negedge CLK);
      START = 1'b1; IS_LOAD = 1'b1; UP = 1'b1; REG_LIST = 16'h0F00; BASE_ADDR = 32'h400;
      @(negedge CLK);
      START = 1'b0;
      chk("rst_beat0_addr", MEM_ADDR, 32'h400);
      MEM_ACK = 1'b1; MEM_RDATA = $urandom;
      @(negedge CLK);
      chk("rst_beat1_addr", MEM_ADDR, 32'h404);
      chk("rst_pre_rfwen", 32'(RF_WEN), 1);
      MEM_ACK = 1'b1; MEM_RDATA = $urandom;
      #1 RST = 1'b1;
      #1 zero_chk("rst_async");
      @(negedge CLK);
      MEM_ACK = 1'b0;
      zero_chk("rst_held");
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_no_wen", 32'(RF_WEN), 0);
      chk("rst_idle", 32'(BUSY), 0);
      chk("rst_no_req", 32'(MEM_REQ), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      repeat (2) @(negedge CLK);
      zero_chk("reset");
      RST = 1'b0;
      run(1'b0, 1'b1, 16'h8003, 32'h100, 0, 0, 1'b0);
      run(1'b1, 1'b0, 16'h0030, 32'h200, 2, 2, 1'b0);
      run(1'b0, 1'b1, 16'h0000, 32'h300, 0, 0, 1'b0);
      run(1'b1, 1'b1, 16'h0000, 32'h304, 0, 0, 1'b1);
      run(1'b0, 1'b1, 16'h0003, 32'hFFFFFFFC, 0, 0, 1'b0);
      run(1'b1, 1'b0, 16'h0001, 32'h00000004, 0, 1, 1'b0);
      reset_mid_ldm();
      run(1'b1, 1'b1, 16'h0F00, 32'h400, 0, 0, 1'b0);
      run(1'b0, 1'b0, 16'hFFFF, 32'h1000, 0, 1, 1'b1);
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 16; i++) rf[i] = $urandom;
         run(1'($urandom), 1'($urandom),
             ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom),
             $urandom, 0, $urandom_range(3, 0), 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
